// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin two-port arbiter that runs each datamem access
// through a fixed IDLE/ACCESS/WAIT/RESP sequence with range checking.
module dm_arbiter #(
  parameter int DW = 16,
  parameter int AW = 16,
  parameter int DEPTH = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p1_req,
  input  logic          p0_we,
  input  logic          p1_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p0_wdata,
  input  logic [DW-1:0] p1_wdata,
  output logic          p0_ack,
  output logic          p1_ack,
  output logic          p0_err,
  output logic          p1_err,
  output logic [DW-1:0] p0_rdata,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  input  logic [DW-1:0] mem_out,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} stateT;
  localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);
  stateT state, nextState;
  logic lastGrant, owner, latWe, rangeOk, anyReq, grant, selWe;
  logic [AW-1:0] selAddr;
  logic [DW-1:0] selData;
  assign anyReq = p0_req | p1_req;
  // On a tie the port that did not win last time gets the grant
  assign grant = (p0_req & p1_req) ? ~lastGrant : p1_req;
  assign selWe = grant ? p1_we : p0_we;
  assign selAddr = grant ? p1_addr : p0_addr;
  assign selData = grant ? p1_wdata : p0_wdata;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nextState;
  always_comb begin
    nextState = state;
    mem_we = 1'b0;
    p0_ack = 1'b0;
    p1_ack = 1'b0;
    p0_err = 1'b0;
    p1_err = 1'b0;
    case (state)
      IDLE: nextState = anyReq ? ACCESS : IDLE;
      ACCESS: begin
        nextState = WAIT;
        mem_we = latWe & rangeOk;
      end
      WAIT: nextState = RESP;
      RESP: begin
        nextState = IDLE;
        p0_ack = ~owner;
        p1_ack = owner;
        p0_err = ~owner & ~rangeOk;
        p1_err = owner & ~rangeOk;
      end
      default: nextState = IDLE;
    endcase
  end
  // mem_addr/mem_data are registers so the memory sees stable values in every state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lastGrant <= 1'b1;
      owner <= 1'b0;
      latWe <= 1'b0;
      rangeOk <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else begin
      if (state == IDLE && anyReq) begin
        owner <= grant;
        lastGrant <= grant;
        latWe <= selWe;
        mem_addr <= selAddr;
        mem_data <= selData;
        rangeOk <= {1'b0, selAddr} < LIMIT;
      end
      if (state == WAIT && !latWe) begin
        if (owner) p1_rdata <= rangeOk ? mem_out : '0;
        else p0_rdata <= rangeOk ? mem_out : '0;
      end
    end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed tests against a transaction-timeline model of the arbiter.
module tb_dm_arbiter;
  localparam int DEPTH = 1024;
  logic clk = 0, rst = 1;
  logic p0_req = 0, p1_req = 0, p0_we = 0, p1_we = 0;
  logic [15:0] p0_addr = 0, p1_addr = 0, p0_wdata = 0, p1_wdata = 0;
  logic p0_ack, p1_ack, p0_err, p1_err, mem_we, busy;
  logic [15:0] p0_rdata, p1_rdata, mem_addr, mem_data, mem_out;
  int total = 0, passed = 0, cycle = 0, weCount = 0, ackTotal = 0;
  int ackLog[$];

  always #5 clk = ~clk;

  dm_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p1_req(p1_req), .p0_we(p0_we), .p1_we(p1_we),
    .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p0_ack(p0_ack), .p1_ack(p1_ack), .p0_err(p0_err), .p1_err(p1_err),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_out(mem_out),
    .busy(busy)
  );

  // datamem stand-in: synchronous write, combinational read
  bit [15:0] mem [1024];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:0]] <= mem_data;
  assign mem_out = mem[mem_addr[9:0]];
  always @(posedge clk) cycle <= cycle + 1;

  // Model: a granted transaction occupies 3 cycles after its grant edge, then one idle edge
  bit active = 0;
  int phase = 0, lastG = 1, curPort = 0;
  bit curWe = 0;
  bit [15:0] curAddr = 0, curData = 0;
  bit [15:0] expRd [2];
  bit [15:0] shadow [1024];

  function automatic int pick(bit r0, bit r1, int lg);
    return (r0 && r1) ? 1 - lg : (r1 ? 1 : 0);
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) begin
      active <= 0; phase <= 0; lastG <= 1; curPort <= 0; curWe <= 0;
      curAddr <= 0; curData <= 0; expRd[0] <= 0; expRd[1] <= 0;
    end else if (active) begin
      phase <= phase + 1;
      if (phase == 2) active <= 0;
      if (phase == 0 && curWe && curAddr < DEPTH) shadow[curAddr[9:0]] <= curData;
      if (phase == 1 && !curWe) expRd[curPort] <= (curAddr < DEPTH) ? shadow[curAddr[9:0]] : 16'h0;
    end else if (p0_req || p1_req) begin
      curPort <= pick(p0_req, p1_req, lastG);
      lastG <= pick(p0_req, p1_req, lastG);
      curWe <= pick(p0_req, p1_req, lastG) == 1 ? p1_we : p0_we;
      curAddr <= pick(p0_req, p1_req, lastG) == 1 ? p1_addr : p0_addr;
      curData <= pick(p0_req, p1_req, lastG) == 1 ? p1_wdata : p0_wdata;
      active <= 1;
      phase <= 0;
    end

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %h expected %h", n, a, e);
    else passed++;
  endtask

  always @(negedge clk) begin
    chk("busy", busy, active);
    chk("mem_we", mem_we, active && phase == 0 && curWe && curAddr < DEPTH);
    chk("mem_addr", mem_addr, curAddr);
    chk("mem_data", mem_data, curData);
    chk("p0_ack", p0_ack, active && phase == 2 && curPort == 0);
    chk("p1_ack", p1_ack, active && phase == 2 && curPort == 1);
    chk("p0_err", p0_err, active && phase == 2 && curPort == 0 && curAddr >= DEPTH);
    chk("p1_err", p1_err, active && phase == 2 && curPort == 1 && curAddr >= DEPTH);
    chk("p0_rdata", p0_rdata, expRd[0]);
    chk("p1_rdata", p1_rdata, expRd[1]);
    if (mem_we) weCount++;
    if (p0_ack) begin ackLog.push_back(0); ackTotal++; end
    if (p1_ack) begin ackLog.push_back(1); ackTotal++; end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(int p, bit we, bit [15:0] a, bit [15:0] d);
    if (p == 0) begin p0_we = we; p0_addr = a; p0_wdata = d; p0_req = 1; end
    else begin p1_we = we; p1_addr = a; p1_wdata = d; p1_req = 1; end
  endtask

  task automatic waitAck(int p, output int lat, output bit err);
    bit seen = 0;
    lat = 0;
    err = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      lat++;
      seen = (p == 0) ? p0_ack : p1_ack;
    end
    if (seen) err = (p == 0) ? p0_err : p1_err;
    else chk($sformatf("ack%0d timeout", p), 0, 1);
  endtask

  task automatic txn(int p, bit we, bit [15:0] a, bit [15:0] d, output int lat, output bit err);
    setReq(p, we, a, d);
    waitAck(p, lat, err);
    if (p == 0) p0_req = 0; else p1_req = 0;
    tick();
  endtask

  initial begin
    int lat, w0, a0, n0, t;
    bit err;
    repeat (2) tick();
    chk("rst busy", busy, 0);
    chk("rst p0_rdata", p0_rdata, 0);
    chk("rst mem_addr", mem_addr, 0);
    rst = 0;
    tick();

    // Simultaneous writes from reset: port 0 first, port 1 four cycles later
    setReq(0, 1, 16'h0010, 16'h1001);
    setReq(1, 1, 16'h0011, 16'hA001);
    waitAck(0, lat, err);
    chk("tie p0 latency", lat, 3);
    chk("tie p1 not yet", p1_ack, 0);
    p0_req = 0;
    waitAck(1, lat, err);
    chk("tie p1 gap", lat, 4);
    p1_req = 0;
    tick();
    txn(0, 0, 16'h0011, 0, lat, err);
    chk("readback 0x11", p0_rdata, 16'hA001);
    txn(1, 0, 16'h0010, 0, lat, err);
    chk("readback 0x10", p1_rdata, 16'h1001);

    // Port-0 write, port-1 read
    w0 = weCount;
    txn(0, 1, 16'h0005, 16'h1DFE, lat, err);
    chk("wr latency", lat, 3);
    chk("wr err", err, 0);
    chk("wr strobe count", weCount - w0, 1);
    txn(1, 0, 16'h0005, 0, lat, err);
    chk("rd latency", lat, 3);
    chk("rd data", p1_rdata, 16'h1DFE);

    // Continuous contention
    setReq(0, 0, 16'h0010, 0);
    setReq(1, 0, 16'h0011, 0);
    ackLog.delete();
    t = 0;
    while (ackLog.size() < 8 && t < 60) begin tick(); t++; end
    p0_req = 0;
    p1_req = 0;
    tick();
    chk("fair ack count", ackLog.size(), 8);
    chk("fair cycles", t, 32);
    n0 = 0;
    foreach (ackLog[i]) begin
      if (ackLog[i] == 0) n0++;
      if (i > 0) chk("fair alternate", ackLog[i] != ackLog[i-1], 1);
    end
    chk("fair p0 share", n0, 4);
    chk("fair p0 data", p0_rdata, 16'h1001);
    chk("fair p1 data", p1_rdata, 16'hA001);

    // Out-of-range write and read
    w0 = weCount;
    txn(1, 1, 16'h0400, 16'hA001, lat, err);
    chk("oor wr err", err, 1);
    chk("oor wr latency", lat, 3);
    chk("oor no strobe", weCount - w0, 0);
    txn(0, 0, 16'h0000, 0, lat, err);
    chk("addr0 unchanged", p0_rdata, 16'h0000);
    chk("addr0 err", err, 0);
    txn(1, 0, 16'h0400, 0, lat, err);
    chk("oor rd err", err, 1);
    chk("oor rd data", p1_rdata, 16'h0000);

    // Reset during ACCESS of a write aborts it
    txn(0, 1, 16'h0020, 16'h1234, lat, err);
    a0 = ackTotal;
    setReq(0, 1, 16'h0020, 16'hBEEF);
    tick();
    chk("abort we before", mem_we, 1);
    #2 rst = 1;
    #1;
    chk("abort we async", mem_we, 0);
    chk("abort busy", busy, 0);
    p0_req = 0;
    tick();
    #2 rst = 0;
    repeat (4) tick();
    chk("abort no ack", ackTotal - a0, 0);
    txn(0, 0, 16'h0020, 0, lat, err);
    chk("abort not written", p0_rdata, 16'h1234);
    txn(1, 0, 16'h0005, 0, lat, err);
    chk("post-reset read", p1_rdata, 16'h1DFE);
    chk("post-reset latency", lat, 3);

    // Dropping req and changing fields after the grant
    setReq(0, 0, 16'h0011, 0);
    tick();
    p0_addr = 16'h0005;
    tick();
    p0_req = 0;
    waitAck(0, lat, err);
    chk("drop latency", lat + 2, 3);
    chk("drop data", p0_rdata, 16'hA001);
    tick();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
